// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
//
// An instruction/PC pair is accepted through a valid/ready handshake, decoded
// combinationally, and then held as a control bundle in the output register.
// A second bundle register (the skid entry) absorbs one instruction while
// execute applies backpressure. Because of this entry, in_ready is a plain
// register bit (!skid_valid) and does not depend on out_ready.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   flush             synchronous discard of held and incoming instructions
//   in_valid/in_ready fetch handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready execute handshake for the bundle below
//   out_pc            PC of the decoded instruction
//   rd, rs1, rs2      register indices, 0 when the format does not use them
//   imm               sign-extended immediate (U-type: upper 20 bits, low 12 zero)
//   alu_op            ALU opcode (ADD=0 .. PASSB=10, M ops 16..23)
//   alu_src_imm       operand B comes from imm
//   reg_write, mem_read, mem_write, branch, jump   control flags
//   mem_size          funct3 for loads/stores, 0 otherwise
//   illegal           undecodable instruction; all control flags forced low
//
// Optional feature macro: DECODE_RV32M_EN
//   When defined, OP with funct7=0000001 decodes to MUL..REMU (alu_op=16+funct3).
//   When undefined, that encoding is reported as illegal.

module decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jump,
    output logic [2:0]          mem_size,
    output logic                illegal
);

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_imm;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic [2:0]          mem_size;
        logic                illegal;
        logic [PC_W-1:0]     pc;
    } bundle_t;

    bundle_t     dec;
    bundle_t     out_q;
    bundle_t     skid_q;
    logic        out_valid_q;
    logic        skid_valid_q;
    logic        take_in;
    logic        drain;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [4:0]  op;
    logic        legal;

    // funct3 -> ALU op for the base register/immediate arithmetic group
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'd0:    r = ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_SLTU;
            3'd4:    r = ALU_XOR;
            3'd5:    r = ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        opcode = in_instr[6:0];
        funct3 = in_instr[14:12];
        funct7 = in_instr[31:25];
        imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
        imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
        imm_u  = {in_instr[31:12], 12'h000};
        imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
        op     = ALU_ADD;
        legal  = 1'b1;
        dec    = '0;
        dec.pc = in_pc;

        // Every legal opcode ends in 2'b11, so a bad instr[1:0] falls to default.
        case (opcode)
            OPC_OP_IMM: begin
                dec.rd          = in_instr[11:7];
                dec.rs1         = in_instr[19:15];
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                op              = base_alu(funct3);
                if (funct3 == 3'd1 && funct7 != 7'b0000000) begin
                    legal = 1'b0;
                end else if (funct3 == 3'd5) begin
                    if (funct7 == 7'b0100000) begin
                        op = ALU_SRA;
                    end else if (funct7 != 7'b0000000) begin
                        legal = 1'b0;
                    end
                end
            end
            OPC_OP: begin
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: op = base_alu(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'd0) begin
                            op = ALU_SUB;
                        end else if (funct3 == 3'd5) begin
                            op = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    7'b0000001: begin
`ifdef DECODE_RV32M_EN
                        op = 5'd16 + {2'b00, funct3};
`else
                        legal = 1'b0;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.rd          = in_instr[11:7];
                dec.rs1         = in_instr[19:15];
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg_write   = 1'b1;
                dec.mem_size    = funct3;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
                    legal = 1'b0;
                end
            end
            OPC_STORE: begin
                dec.rs1         = in_instr[19:15];
                dec.rs2         = in_instr[24:20];
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                dec.mem_size    = funct3;
                if (funct3 > 3'd2) begin
                    legal = 1'b0;
                end
            end
            OPC_BRANCH: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                op         = ALU_SUB;
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    legal = 1'b0;
                end
            end
            OPC_JAL: begin
                dec.rd        = in_instr[11:7];
                dec.imm       = imm_j;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.rd        = in_instr[11:7];
                dec.rs1       = in_instr[19:15];
                dec.imm       = imm_i;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                if (funct3 != 3'd0) begin
                    legal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec.rd          = in_instr[11:7];
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                op              = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.rd          = in_instr[11:7];
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        dec.alu_op = ALU_OP_W'(op);

        // An illegal token still flows downstream, but as an inert bundle.
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !skid_valid_q;
    assign take_in  = in_valid && in_ready;
    assign drain    = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                // take_in is always low here (in_ready = !skid_valid), so the
                // skid simply empties; kept general for clarity of intent.
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= take_in;
                if (take_in) begin
                    skid_q <= dec;
                end
            end else begin
                if (take_in) begin
                    out_q <= dec;
                end
                out_valid_q <= take_in;
            end
        end else if (take_in) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign rd          = out_q.rd;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign imm         = out_q.imm;
    assign alu_op      = out_q.alu_op;
    assign alu_src_imm = out_q.alu_src_imm;
    assign reg_write   = out_q.reg_write;
    assign mem_read    = out_q.mem_read;
    assign mem_write   = out_q.mem_write;
    assign branch      = out_q.branch;
    assign jump        = out_q.jump;
    assign mem_size    = out_q.mem_size;
    assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus a randomized stream,
// checked through an expected-bundle queue and an independent output monitor.
// Compile with the same DECODE_RV32M_EN setting as the design.

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump;
    logic [2:0]  mem_size;
    logic        illegal;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump),
        .mem_size(mem_size), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        int          rd, rs1, rs2, alu, msize;
        bit          src, rw, mr, mw, br, jp, ill;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    // Reference decode written from the ISA tables with shifts and masks.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int   opc = ins & 32'h7f;
        int   f3  = (ins >> 12) & 7;
        int   f7  = (ins >> 25) & 127;
        int   fr  = (ins >> 7) & 31;
        int   f1  = (ins >> 15) & 31;
        int   f2  = (ins >> 20) & 31;
        logic [31:0] i_imm = sext(ins >> 20, 12);
        logic [31:0] s_imm = sext((((ins >> 25) & 127) << 5) | fr, 12);
        logic [31:0] b_imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                                  (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
        logic [31:0] j_imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                                  (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
        e = '{instr: ins, pc: pc, imm: 0, rd: 0, rs1: 0, rs2: 0, alu: 0, msize: 0,
              src: 0, rw: 0, mr: 0, mw: 0, br: 0, jp: 0, ill: 0};
        case (opc)
            'h13: begin
                e.rd = fr; e.rs1 = f1; e.imm = i_imm; e.src = 1; e.rw = 1;
                e.alu = (f3 == 5 && f7 == 32) ? 7 : base_op[f3];
                e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            'h33: begin
                e.rd = fr; e.rs1 = f1; e.rs2 = f2; e.rw = 1;
                if (f7 == 0) e.alu = base_op[f3];
                else if (f7 == 32 && f3 == 0) e.alu = 1;
                else if (f7 == 32 && f3 == 5) e.alu = 7;
                else if (f7 == 1 && M_EN) e.alu = 16 + f3;
                else e.ill = 1;
            end
            'h03: begin
                e.rd = fr; e.rs1 = f1; e.imm = i_imm; e.src = 1; e.mr = 1; e.rw = 1;
                e.msize = f3; e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            'h23: begin
                e.rs1 = f1; e.rs2 = f2; e.imm = s_imm; e.src = 1; e.mw = 1;
                e.msize = f3; e.ill = (f3 > 2);
            end
            'h63: begin
                e.rs1 = f1; e.rs2 = f2; e.imm = b_imm; e.br = 1; e.alu = 1;
                e.ill = (f3 == 2 || f3 == 3);
            end
            'h6f: begin e.rd = fr; e.imm = j_imm; e.jp = 1; e.rw = 1; end
            'h67: begin
                e.rd = fr; e.rs1 = f1; e.imm = i_imm; e.jp = 1; e.rw = 1; e.ill = (f3 != 0);
            end
            'h37: begin e.rd = fr; e.imm = ins & 32'hffff_f000; e.alu = 10; e.src = 1; e.rw = 1; end
            'h17: begin e.rd = fr; e.imm = ins & 32'hffff_f000; e.src = 1; e.rw = 1; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: compares every bundle that execute actually takes.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (flush) begin
                    exp_q.delete();
                end else if (out_valid && out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_bundle: got pc=%h, required no output", out_pc);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (illegal == e.ill) && (reg_write == e.rw) && (mem_read == e.mr) &&
                             (mem_write == e.mw) && (branch == e.br) && (jump == e.jp) &&
                             (out_pc == e.pc);
                        if (!e.ill)
                            ok = ok && (int'(rd) == e.rd) && (int'(rs1) == e.rs1) &&
                                 (int'(rs2) == e.rs2) && (imm == e.imm) &&
                                 (int'(alu_op) == e.alu) && (alu_src_imm == e.src) &&
                                 (int'(mem_size) == e.msize);
                        if (!ok) begin
                            miscompares++;
                            $display("FAIL bundle instr=%h: got pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h alu=%0d src=%b rw=%b mr=%b mw=%b br=%b jp=%b msz=%0d ill=%b, required pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h alu=%0d src=%b rw=%b mr=%b mw=%b br=%b jp=%b msz=%0d ill=%b",
                                     e.instr, out_pc, rd, rs1, rs2, imm, alu_op, alu_src_imm,
                                     reg_write, mem_read, mem_write, branch, jump, mem_size, illegal,
                                     e.pc, e.rd, e.rs1, e.rs2, e.imm, e.alu, e.src, e.rw, e.mr,
                                     e.mw, e.br, e.jp, e.msize, e.ill);
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input bit rnd);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc_ctr;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (!flush) exp_q.push_back(model(ins, pc_ctr));
                break;
            end
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 4;
        if (rnd) out_ready = ($urandom % 4) != 0;
    endtask

    function automatic logic [31:0] rand_instr();
        int          opcs[9] = '{'h13, 'h33, 'h03, 'h23, 'h63, 'h6f, 'h67, 'h37, 'h17};
        logic [31:0] ins = $urandom;
        int          k;
        if ($urandom % 8 == 0) return ins;
        ins[6:0] = 7'(opcs[$urandom % 9]);
        if (ins[6:0] == 7'h13 || ins[6:0] == 7'h33) begin
            k = $urandom % 4;
            ins[31:25] = (k == 0) ? 7'd0 : (k == 1) ? 7'd32 : (k == 2) ? 7'd1 : 7'($urandom);
        end
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic decode and one-cycle latency
        out_ready = 1'b1;
        send(32'h0050_0093, 0);
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_imm", imm, 32'd5);
        @(posedge clk); #1;
        send(32'hFFF0_8113, 0);
        @(negedge clk);
        chk("addi_neg_imm", imm, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        send(32'h4020_81B3, 0);
        @(negedge clk);
        chk("sub_alu_op", 32'(alu_op), 32'd1);
        @(posedge clk); #1;

        // Backpressure: output held, skid fills, third instruction stalls
        out_ready = 1'b0;
        send(32'h0010_0213, 0);
        send(32'h0020_0293, 0);
        in_valid = 1'b1; in_instr = 32'h0030_0313;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            send(32'h0030_0313, 0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_consecutive_valid", 32'(out_valid), 32'd1);
                end
            end
        join
        @(posedge clk); #1;

        // Illegal and M-extension encodings
        send(32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("ill_ones", 32'(illegal), 32'd1);
        @(posedge clk); #1;
        send(32'h0000_0000, 0);
        @(negedge clk);
        chk("ill_zero_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        send(32'h0220_81B3, 0);
        @(negedge clk);
        chk("mul_illegal", 32'(illegal), M_EN ? 32'd0 : 32'd1);
        @(posedge clk); #1;

        // Flush with output held and skid full
        out_ready = 1'b0;
        send(32'h0070_0393, 0);
        send(32'h0080_0413, 0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0090_0493;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00A0_0513, 0);
        @(negedge clk);
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h00B0_0593, 0);
        send(32'h00C0_0613, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_reg_write", 32'(reg_write), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized stream with random backpressure and occasional flush
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 40 == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
            send(rand_instr(), 1);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("final_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage, replacing the single-cycle combinational decoder.
- Sits between fetch and execute. Accepts an instruction and PC through a valid/ready handshake, fully decodes all base formats (R/I/S/B/U/J), and emits a registered control bundle.
- A two-entry skid buffer sustains 1 instruction/cycle under backpressure. Supports pipeline flush.

Parameters:
- XLEN, 32, data/immediate width; only 32 is supported.
- PC_W, 32, program-counter width.
- ALU_OP_W, 5, ALU opcode width; must be at least 5.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all held and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_W  PC of the decoded instruction.
- rd, rs1, rs2  out  5 each  register indices; 0 when unused by the format.
- imm  out  XLEN  sign-extended immediate for the format (U-type: imm[31:12] with low 12 bits zero).
- alu_op  out  ALU_OP_W  ALU opcode.
- alu_src_imm  out  1  ALU operand B is imm.
- reg_write, mem_read, mem_write, branch, jump  out  1 each  control flags.
- mem_size  out  3  funct3 for loads/stores; 0 otherwise.
- illegal  out  1  undecodable instruction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, skid_valid=0, in_ready=1.
  - All bundle outputs 0, out_pc=0.
- in_ready = !skid_valid. It is registered state only, with no combinational path from out_ready.
- Transfer rules:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
- Latency: 1 cycle. A bundle is visible the cycle after acceptance when the output register is free or draining.
- Each cycle, in priority order:
  1. flush=1: out_valid<=0, skid_valid<=0; any same-cycle input transfer is dropped. Flush wins over all other events.
  2. Output register empty or draining:
     - If skid_valid, the skid contents move to output and the skid loads the new input if one is transferred.
     - Otherwise the new input, decoded, goes to output.
     - out_valid reflects whether anything was loaded.
  3. Output held (out_valid&&!out_ready) and an input is transferred: decode into the skid; skid_valid<=1.
- Order is preserved; no instruction is lost or duplicated.
- Decoding is combinational on in_instr. Both the output and skid registers hold decoded bundles.
- ALU codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - 16–23 are reserved for M ops.
- Per-opcode decode:
  - OP-IMM (0010011): alu from funct3; SRAI when funct7=0100000; alu_src_imm=1; reg_write=1.
  - OP (0110011): funct7 0000000 → base ops; 0100000 → SUB/SRA only.
  - LOAD (0000011): ADD, alu_src_imm=1, mem_read=1, reg_write=1.
  - STORE (0100011): ADD, alu_src_imm=1, mem_write=1, rd=0.
  - BRANCH (1100011): alu=SUB, branch=1, rd=0.
  - JAL (1101111) / JALR (1100111): jump=1, reg_write=1, alu=ADD.
  - LUI (0110111): PASSB, alu_src_imm=1.
  - AUIPC (0010111): ADD, alu_src_imm=1.
- Illegal conditions:
  - Any other opcode, instr[1:0]≠11, an invalid funct7/funct3 combination, or JALR funct3≠000.
  - Result: illegal=1; reg_write, mem_read, mem_write, branch and jump all 0; the token still flows as valid.
- Writes with rd=0 keep reg_write as decoded; the regfile ignores x0.

Optional Feature:
- Macro DECODE_RV32M_EN.
- Defined: OP with funct7=0000001 decodes to MUL..REMU, alu_op=16+funct3, reg_write=1.
- Undefined: that encoding is illegal=1.

Test Plan:
- Reset then in_instr=0x00500093 (ADDI x1,x0,5), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, alu_src_imm=1, reg_write=1.
- 0xFFF08113 (ADDI x2,x1,-1) → imm=0xFFFFFFFF, rs1=1, rd=2. Then 0x402081B3 → alu_op=1, alu_src_imm=0, rs2=2, rd=3.
- Backpressure: out_ready=0, stream 3 instructions → first held at output, second in skid, in_ready=0 on the third. Raise out_ready → all 3 emerge in order on consecutive cycles, none lost.
- 0xFFFFFFFF and 0x00000000 → illegal=1, reg_write=mem_write=branch=jump=0, out_valid=1.
- 0x022081B3 (MUL x3,x1,x2) → with DECODE_RV32M_EN alu_op=16, illegal=0; without it illegal=1.
- Output held and skid full, assert flush for 1 cycle → next cycle out_valid=0, in_ready=1. Both buffered instructions never appear. rst_n low mid-stream → immediate clear.
